// File: rtl/sd_power_sequencer.sv
// SD card power sequencer: enforces the minimum power-off time, the VDD ramp
// delay and the initialisation clock burst before reporting the card ready,
// and cuts power immediately when the host or the card goes away.
module sd_power_sequencer #(
   parameter int RampPeriod = 500000,
   parameter int OffPeriod  = 50000,
   parameter int InitClocks = 74
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic power_req_i,
   input  logic card_inserted_i,
   input  logic card_removal_i,
   input  logic sd_clk_tick_i,
   output logic sd_power_en_o,
   output logic init_clk_en_o,
   output logic power_ready_o,
   output logic power_fault_o
);

   localparam int MaxPeriod = (RampPeriod > OffPeriod) ? RampPeriod : OffPeriod;
   localparam int CntW      = $clog2(MaxPeriod + 1);
   localparam int TickW     = $clog2(InitClocks + 1);

   localparam logic [CntW-1:0]  RampLoad = CntW'(RampPeriod - 1);
   localparam logic [CntW-1:0]  OffLoad  = CntW'(OffPeriod - 1);
   localparam logic [TickW-1:0] TickLoad = TickW'(InitClocks - 1);

   typedef enum logic [2:0] {
      HOLDOFF = 3'd0,
      OFF     = 3'd1,
      RAMP    = 3'd2,
      INIT    = 3'd3,
      READY   = 3'd4
   } state_t;

   state_t           r_state, w_state_nxt;
   logic [CntW-1:0]  r_cnt, w_cnt_nxt;
   logic [TickW-1:0] r_tick, w_tick_nxt;
   logic             r_fault, w_fault_nxt;
   logic             r_pwr_en, r_init_en, r_ready;

   logic             w_powered;
   logic             w_card_gone;
   logic             w_abort;

   // Any loss of card or host request while powered aborts the sequence.
   assign w_powered   = (r_state == RAMP) || (r_state == INIT) || (r_state == READY);
   assign w_card_gone = card_removal_i || !card_inserted_i;
   assign w_abort     = w_powered && (w_card_gone || !power_req_i);

   // Next-state logic; abort overrides every other transition.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_tick_nxt  = r_tick;
      w_fault_nxt = r_fault;

      case (r_state)
         HOLDOFF: begin
            // Inputs ignored here so the off time can never be shortened.
            if (r_cnt == '0) w_state_nxt = OFF;
            else             w_cnt_nxt   = r_cnt - 1'b1;
         end
         OFF: begin
            if (power_req_i && card_inserted_i && !card_removal_i) begin
               w_state_nxt = RAMP;
               w_cnt_nxt   = RampLoad;
            end
         end
         RAMP: begin
            // Ticks are not looked at here, so none can be counted early.
            if (r_cnt == '0) begin
               w_state_nxt = INIT;
               w_tick_nxt  = TickLoad;
            end else begin
               w_cnt_nxt = r_cnt - 1'b1;
            end
         end
         INIT: begin
            if (sd_clk_tick_i) begin
               if (r_tick == '0) w_state_nxt = READY;
               else              w_tick_nxt  = r_tick - 1'b1;
            end
         end
         READY: begin
         end
         default: begin
            w_state_nxt = HOLDOFF;
            w_cnt_nxt   = OffLoad;
         end
      endcase

      if (w_abort) begin
         w_state_nxt = HOLDOFF;
         w_cnt_nxt   = OffLoad;
      end

      // Fault is sticky until the host drops its request; setting wins.
      if (w_abort && w_card_gone) w_fault_nxt = 1'b1;
      else if (!power_req_i)      w_fault_nxt = 1'b0;
   end

   // State, counters and outputs registered together from the next state.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state   <= HOLDOFF;
         r_cnt     <= OffLoad;
         r_tick    <= '0;
         r_fault   <= 1'b0;
         r_pwr_en  <= 1'b0;
         r_init_en <= 1'b0;
         r_ready   <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_cnt     <= w_cnt_nxt;
         r_tick    <= w_tick_nxt;
         r_fault   <= w_fault_nxt;
         r_pwr_en  <= (w_state_nxt == RAMP) || (w_state_nxt == INIT) ||
                      (w_state_nxt == READY);
         r_init_en <= (w_state_nxt == INIT);
         r_ready   <= (w_state_nxt == READY);
      end
   end

   assign sd_power_en_o = r_pwr_en;
   assign init_clk_en_o = r_init_en;
   assign power_ready_o = r_ready;
   assign power_fault_o = r_fault;

endmodule
